tx_symbol_mapper: RTL and testbench
===================================

// Module: tx_symbol_mapper
// PURPOSE
//  Consumes the AXIS bit stream from the Tx data source and maps each beat to one
//  BPSK/QPSK baseband symbol (signed I/Q). Holds each symbol for SYM_CYCLES clocks.
//  Paces upstream via s_tready, one beat per symbol period, and feeds the Tx pulse-shaping/DUC path.
// PARAMETERS
//  BYTES      1     AXIS tdata width in bytes (tdata = BYTES*8 bits, >=1)
//  SYM_CYCLES 8     clocks per symbol (>=2)
//  OUT_W      12    signed width of i_out/q_out
//  AMP        1448  symbol magnitude, 0 < AMP <= 2^(OUT_W-1)-1
// PORTS
//  clk          in   1        system clock, rising edge
//  rst_n        in   1        async active-low reset
//  s_tdata      in   BYTES*8  bit[1]=I bit, bit[0]=Q bit, upper bits ignored
//  s_tvalid     in   1        upstream beat valid
//  s_tready     out  1        beat accepted when s_tvalid & s_tready
//  s_tlast      in   1        last beat of frame
//  s_tuser      in   1        1 = BPSK, 0 = QPSK (per beat)
//  i_out        out  OUT_W    signed in-phase symbol
//  q_out        out  OUT_W    signed quadrature symbol
//  sym_start    out  1        1-cycle pulse on first clock of each new symbol
//  is_bpsk_out  out  1        modulation of symbol currently on i_out/q_out
//  frame_end    out  1        1-cycle pulse with sym_start of a tlast symbol
//  underflow    out  1        1-cycle pulse: period ended mid-frame with no beat
// BEHAVIOUR
//  Reset (async, rst_n=0): state=IDLE, cnt=0, in_frame=0. All outputs 0, incl. s_tready.
//  - First clock after release: s_tready=1.
//  Mapping: bit 0 -> +AMP, bit 1 -> -AMP.
//  - BPSK: I from bit[1], Q=0.
//  - QPSK: I from bit[1], Q from bit[0].
//  - Negation is in OUT_W two's complement; never wraps because AMP < 2^(OUT_W-1).
//  FSM IDLE:
//  - s_tready=1; i_out=q_out=0.
//  - On handshake at cycle t: register symbol, go SYM, cnt=0.
//  - sym_start=1 at t+1 (latency 1 clk).
//  FSM SYM:
//  - cnt increments 0..SYM_CYCLES-1; i/q/is_bpsk_out held constant.
//  - s_tready=1 only when cnt==SYM_CYCLES-1; combinational from state/cnt, not from s_tvalid.
//  - At cnt==SYM_CYCLES-1 with handshake: load next symbol, cnt=0, sym_start next cycle.
//    Gives back-to-back symbols with no gap.
//  - At cnt==SYM_CYCLES-1 without handshake: go IDLE; i/q=0 next cycle.
//    If in_frame=1, pulse underflow that same next cycle.
//  in_frame:
//  - Set on accepted beat with s_tlast=0.
//  - Cleared on accepted beat with s_tlast=1.
//  - Cleared on reset.
//  frame_end: asserted together with sym_start of a symbol whose beat had s_tlast=1.
//  s_tuser may change on every beat; mapping follows each beat's own tuser.
//  s_tvalid high while s_tready low: no acceptance; upstream holds data (AXIS rules).
//  Reset mid-symbol: outputs zero immediately; the partial symbol is discarded.
// TESTING
//  1 BPSK: tuser=1, tdata=0x02,0x00, tvalid=1 -> i=-1448 for 8 clks, then +1448; q=0.
//    sym_start every 8 clks; s_tready high 1 of 8 clks.
//  2 QPSK: tuser=0, tdata=0x01 -> i=+1448, q=-1448.
//    tdata=0x03 -> i=q=-1448; handshake->sym_start latency = 1 clk.
//  3 Underflow: 3 beats, tlast=0, then tvalid=0 -> after 3rd symbol: i=q=0, one underflow pulse.
//    Repeat with tlast=1 on 3rd beat -> frame_end with 3rd sym_start; no underflow.
//  4 Gap/resume: tvalid=0 for 20 clks from IDLE -> s_tready stays 1, outputs 0.
//    Then tvalid=1 -> symbol next clk.
//  5 Reset mid-symbol: rst_n=0 at cnt=4 -> all outputs 0 asynchronously.
//    After release: s_tready=1; first beat produces sym_start 1 clk after handshake.
//  6 Mixed modulation + random tready-stall checker: per-beat tuser alternation maps correctly.
//    No beat lost or duplicated over 1000 PN beats (compare vs reference model).

Source files
------------

// File: rtl/tx_symbol_mapper_if.sv
// AXI-Stream bit-beat bus between the Tx data source and the symbol mapper.
// tuser selects BPSK (1) or QPSK (0) for each beat.
interface tx_symbol_mapper_if #(
    parameter int BYTES = 1
);
    logic [BYTES*8-1:0] s_tdata;
    logic               s_tvalid;
    logic               s_tready;
    logic               s_tlast;
    logic               s_tuser;

    modport master (
        output s_tdata,
        output s_tvalid,
        output s_tlast,
        output s_tuser,
        input  s_tready
    );

    modport slave (
        input  s_tdata,
        input  s_tvalid,
        input  s_tlast,
        input  s_tuser,
        output s_tready
    );
endinterface

// File: rtl/tx_symbol_mapper.sv
// Maps each accepted AXIS beat to a BPSK/QPSK I/Q symbol held for SYM_CYCLES clocks,
// pacing upstream so exactly one beat is taken per symbol period.
module tx_symbol_mapper #(
    parameter int BYTES      = 1,
    parameter int SYM_CYCLES = 8,
    parameter int OUT_W      = 12,
    parameter int AMP        = 1448
) (
    input  logic                    clk,
    input  logic                    rst_n,
    tx_symbol_mapper_if.slave       axis,
    output logic signed [OUT_W-1:0] i_out,
    output logic signed [OUT_W-1:0] q_out,
    output logic                    sym_start,
    output logic                    is_bpsk_out,
    output logic                    frame_end,
    output logic                    underflow
);

    localparam int CNT_W = $clog2(SYM_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SYM_CYCLES - 1);
    localparam logic signed [OUT_W-1:0] AMP_POS = OUT_W'(AMP);
    localparam logic signed [OUT_W-1:0] AMP_NEG = OUT_W'(-AMP);

    typedef enum logic {IDLE, SYM} state_t;

    state_t                  state_reg,    state_next;
    logic [CNT_W-1:0]        cnt_reg,      cnt_next;
    logic signed [OUT_W-1:0] i_reg,        i_next;
    logic signed [OUT_W-1:0] q_reg,        q_next;
    logic                    bpsk_reg,     bpsk_next;
    logic                    start_reg,    start_next;
    logic                    fend_reg,     fend_next;
    logic                    uf_reg,       uf_next;
    logic                    in_frame_reg, in_frame_next;
    // Keeps s_tready low until the first clock after reset release.
    logic                    live_reg;

    logic                    period_end;
    logic                    accept;
    logic signed [OUT_W-1:0] bit_amp [2];
    logic                    unused_tdata;

    assign unused_tdata = ^axis.s_tdata;
    assign period_end   = (cnt_reg == CNT_LAST);
    assign accept       = axis.s_tvalid & axis.s_tready;

    // Bit 0 maps to +AMP, bit 1 to -AMP; index 1 feeds I, index 0 feeds Q.
    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_map
            assign bit_amp[gi] = axis.s_tdata[gi] ? AMP_NEG : AMP_POS;
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg    <= IDLE;
            cnt_reg      <= '0;
            i_reg        <= '0;
            q_reg        <= '0;
            bpsk_reg     <= 1'b0;
            start_reg    <= 1'b0;
            fend_reg     <= 1'b0;
            uf_reg       <= 1'b0;
            in_frame_reg <= 1'b0;
            live_reg     <= 1'b0;
        end else begin
            state_reg    <= state_next;
            cnt_reg      <= cnt_next;
            i_reg        <= i_next;
            q_reg        <= q_next;
            bpsk_reg     <= bpsk_next;
            start_reg    <= start_next;
            fend_reg     <= fend_next;
            uf_reg       <= uf_next;
            in_frame_reg <= in_frame_next;
            live_reg     <= 1'b1;
        end
    end

    always_comb begin
        state_next    = state_reg;
        cnt_next      = cnt_reg;
        i_next        = i_reg;
        q_next        = q_reg;
        bpsk_next     = bpsk_reg;
        in_frame_next = in_frame_reg;
        start_next    = 1'b0;
        fend_next     = 1'b0;
        uf_next       = 1'b0;

        unique case (state_reg)
            IDLE: state_next = accept ? SYM : IDLE;
            SYM:  state_next = (period_end && !accept) ? IDLE : SYM;
            default: state_next = IDLE;
        endcase

        if (accept) begin
            cnt_next      = '0;
            i_next        = bit_amp[1];
            q_next        = axis.s_tuser ? '0 : bit_amp[0];
            bpsk_next     = axis.s_tuser;
            start_next    = 1'b1;
            fend_next     = axis.s_tlast;
            in_frame_next = ~axis.s_tlast;
        end else if (state_reg == SYM) begin
            if (period_end) begin
                // Starved at the end of a period: drop to zero output.
                cnt_next  = '0;
                i_next    = '0;
                q_next    = '0;
                bpsk_next = 1'b0;
                uf_next   = in_frame_reg;
            end else begin
                cnt_next = cnt_reg + CNT_W'(1);
            end
        end
    end

    always_comb begin
        axis.s_tready = live_reg & ((state_reg == IDLE) | period_end);
        i_out         = i_reg;
        q_out         = q_reg;
        is_bpsk_out   = bpsk_reg;
        sym_start     = start_reg;
        frame_end     = fend_reg;
        underflow     = uf_reg;
    end

endmodule

// File: tb/tb_tx_symbol_mapper.sv
// Randomized bench for tx_symbol_mapper: a symbol-timer reference model is checked every
// cycle, plus hand-computed literal expectations for the directed scenarios.
module tb_tx_symbol_mapper;

    localparam int BYTES = 1;
    localparam int SC    = 8;
    localparam int OUT_W = 12;
    localparam int AMP   = 1448;
    localparam int LIM   = 4 * SC + 8;

    logic clk = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    tx_symbol_mapper_if #(.BYTES(BYTES)) axis ();

    logic signed [OUT_W-1:0] i_out, q_out;
    logic sym_start, is_bpsk_out, frame_end, underflow;

    tx_symbol_mapper #(
        .BYTES(BYTES), .SYM_CYCLES(SC), .OUT_W(OUT_W), .AMP(AMP)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .axis       (axis),
        .i_out      (i_out),
        .q_out      (q_out),
        .sym_start  (sym_start),
        .is_bpsk_out(is_bpsk_out),
        .frame_end  (frame_end),
        .underflow  (underflow)
    );

    int vectors = 0;
    int miscompares = 0;
    int cyc = 0;
    bit cmp_en = 1'b0;

    int n_start = 0, n_fend = 0, n_uf = 0;
    int n_acc = 0, n_last_acc = 0;

    task automatic check(input string name, input int act, input int exp);
        vectors++;
        if (act != exp) begin
            miscompares++;
            $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int amp_of(input logic b);
        return b ? -AMP : AMP;
    endfunction

    // Reference model: a symbol is a value shown for SC clocks; m_left counts clocks remaining.
    int m_left = 0, m_i = 0, m_q = 0;
    bit m_bpsk = 0, m_start = 0, m_fend = 0, m_uf = 0, m_in_frame = 0, m_live = 0;
    logic m_ready, m_acc;
    assign m_ready = m_live && (m_left <= 1);
    assign m_acc   = axis.s_tvalid && m_ready;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_left <= 0; m_i <= 0; m_q <= 0; m_bpsk <= 0;
            m_start <= 0; m_fend <= 0; m_uf <= 0; m_in_frame <= 0; m_live <= 0;
        end else begin
            m_live  <= 1;
            m_start <= 0;
            m_fend  <= 0;
            m_uf    <= 0;
            if (m_acc) begin
                m_left     <= SC;
                m_i        <= amp_of(axis.s_tdata[1]);
                m_q        <= axis.s_tuser ? 0 : amp_of(axis.s_tdata[0]);
                m_bpsk     <= axis.s_tuser;
                m_start    <= 1;
                m_fend     <= axis.s_tlast;
                m_in_frame <= !axis.s_tlast;
            end else if (m_left == 1) begin
                m_left <= 0; m_i <= 0; m_q <= 0; m_bpsk <= 0;
                m_uf   <= m_in_frame;
            end else if (m_left > 1) begin
                m_left <= m_left - 1;
            end
        end
    end

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (cmp_en) begin
            check("s_tready",    int'(axis.s_tready), int'(m_ready));
            check("i_out",       int'(i_out),         m_i);
            check("q_out",       int'(q_out),         m_q);
            check("is_bpsk_out", int'(is_bpsk_out),   int'(m_bpsk));
            check("sym_start",   int'(sym_start),     int'(m_start));
            check("frame_end",   int'(frame_end),     int'(m_fend));
            check("underflow",   int'(underflow),     int'(m_uf));
            if (sym_start) n_start++;
            if (frame_end) n_fend++;
            if (underflow) n_uf++;
        end
    end

    // Presents one beat and returns 1 ns after the accepting clock edge.
    task automatic send_beat(input logic [7:0] d, input logic user, input logic last);
        int waited = 0;
        axis.s_tdata  = d;
        axis.s_tuser  = user;
        axis.s_tlast  = last;
        axis.s_tvalid = 1'b1;
        @(negedge clk);
        while (!axis.s_tready && waited < LIM) begin
            @(negedge clk);
            waited++;
        end
        if (!axis.s_tready) begin
            vectors++;
            miscompares++;
            $display("FAIL handshake_timeout: got no s_tready, expected within %0d clks at %0t", LIM, $time);
            axis.s_tvalid = 1'b0;
            return;
        end
        @(posedge clk);
        #1;
        n_acc++;
        if (last) n_last_acc++;
    endtask

    task automatic idle(input int n);
        axis.s_tvalid = 1'b0;
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        int c0, s1, uf0, fe0, st0, acc0, la0;
        logic [7:0] d;
        logic       u, l;
        int         gap;

        axis.s_tdata  = '0;
        axis.s_tvalid = 1'b0;
        axis.s_tlast  = 1'b0;
        axis.s_tuser  = 1'b0;

        // Reset state
        #2 rst_n = 1'b0;
        cmp_en = 1'b1;
        #1;
        check("rst_tready", int'(axis.s_tready), 0);
        check("rst_i",      int'(i_out), 0);
        check("rst_q",      int'(q_out), 0);
        repeat (3) @(posedge clk);
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("rel_tready", int'(axis.s_tready), 1);

        // 1: BPSK, back-to-back symbols, period SC
        send_beat(8'h02, 1'b1, 1'b0);
        s1 = cyc;
        check("t1_sym_start", int'(sym_start), 1);
        check("t1_i_neg",     int'(i_out), -1448);
        check("t1_q_zero",    int'(q_out), 0);
        check("t1_bpsk",      int'(is_bpsk_out), 1);
        send_beat(8'h00, 1'b1, 1'b0);
        check("t1_period",    cyc - s1, SC);
        check("t1_i_pos",     int'(i_out), 1448);

        // 2: QPSK
        send_beat(8'h01, 1'b0, 1'b0);
        check("t2_i_01", int'(i_out), 1448);
        check("t2_q_01", int'(q_out), -1448);
        check("t2_qpsk", int'(is_bpsk_out), 0);
        send_beat(8'h03, 1'b0, 1'b0);
        check("t2_i_03", int'(i_out), -1448);
        check("t2_q_03", int'(q_out), -1448);
        check("t2_latency", int'(sym_start), 1);
        idle(3 * SC);

        // 3: underflow mid-frame, then a properly terminated frame
        uf0 = n_uf;
        send_beat(8'h00, 1'b1, 1'b0);
        send_beat(8'h01, 1'b1, 1'b0);
        send_beat(8'h02, 1'b0, 1'b0);
        idle(3 * SC);
        check("t3_uf_count", n_uf - uf0, 1);
        check("t3_i_zero",   int'(i_out), 0);
        uf0 = n_uf;
        fe0 = n_fend;
        send_beat(8'h00, 1'b0, 1'b0);
        send_beat(8'h03, 1'b1, 1'b0);
        send_beat(8'h02, 1'b0, 1'b1);
        check("t3_frame_end", int'(frame_end), 1);
        idle(3 * SC);
        check("t3_no_uf",   n_uf - uf0, 0);
        check("t3_fe_count", n_fend - fe0, 1);

        // 4: long gap from IDLE then resume
        axis.s_tvalid = 1'b0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            check("t4_ready", int'(axis.s_tready), 1);
            check("t4_i", int'(i_out), 0);
        end
        @(posedge clk);
        #1;
        c0 = cyc;
        send_beat(8'h02, 1'b0, 1'b1);
        check("t4_resume_lat", cyc - c0, 1);
        check("t4_i", int'(i_out), -1448);
        check("t4_q", int'(q_out), 1448);
        idle(2 * SC);

        // 5: reset at cnt=4
        send_beat(8'h01, 1'b1, 1'b0);
        axis.s_tvalid = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        check("t5_pre_i", int'(i_out), 1448);
        #1 rst_n = 1'b0;
        #1;
        check("t5_rst_i",     int'(i_out), 0);
        check("t5_rst_q",     int'(q_out), 0);
        check("t5_rst_bpsk",  int'(is_bpsk_out), 0);
        check("t5_rst_ready", int'(axis.s_tready), 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("t5_rel_ready", int'(axis.s_tready), 1);
        c0 = cyc;
        send_beat(8'h02, 1'b0, 1'b0);
        check("t5_lat", cyc - c0, 1);
        check("t5_sym_start", int'(sym_start), 1);
        idle(2 * SC);

        // 6: PN beats with random modulation, framing and gaps
        st0  = n_start;
        fe0  = n_fend;
        acc0 = n_acc;
        la0  = n_last_acc;
        for (int k = 0; k < 1000; k++) begin
            d = 8'($urandom_range(0, 255));
            u = 1'($urandom_range(0, 1));
            l = ($urandom_range(0, 7) == 0);
            gap = ($urandom_range(0, 3) == 0) ? $urandom_range(1, SC + 3) : 0;
            if (gap != 0) idle(gap);
            send_beat(d, u, l);
        end
        idle(2 * SC);
        check("t6_beats",  n_start - st0, n_acc - acc0);
        check("t6_frames", n_fend - fe0, n_last_acc - la0);

        cmp_en = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
